// File: rtl/ts_pkt_pkg.sv
// ts_pkt_pkg: shared framing constants, FSM state type and record sizing for the record packetizer
package ts_pkt_pkg;
    localparam logic [7:0] MAGIC = 8'hA5;
    localparam int HDR_BYTES = 3;
    typedef enum logic [1:0] {IDLE, HDR, REC} state_t;
    function automatic int rec_bytes(input int ts_w);
        return 1 + 3 * (ts_w / 8);
    endfunction
    function automatic int rec_width(input int id_w, input int ts_w);
        return id_w + 3 * ts_w;
    endfunction
endpackage

// File: rtl/ts_record_fifo.sv
// ts_record_fifo: synchronous record FIFO with registered count and combinational head
module ts_record_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [W-1:0]                 din_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 dout_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;
    assign full_o  = cnt_q == FULL;
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // storage needs no reset: pointers and count alone define what is valid
    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= din_i;
    // pointer and occupancy tracking
    always_ff @(posedge clk)
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q == LAST ? '0 : wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q == LAST ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/ts_record_packetizer.sv
// ts_record_packetizer: buffers timestamp records and frames them into a byte stream of packets
module ts_record_packetizer
    import ts_pkt_pkg::*;
#(
    parameter int ID_W          = 4,
    parameter int TS_W          = 64,
    parameter int RECS_PER_PKT  = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int FLUSH_TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_id,
    input  logic [TS_W-1:0] in_start_ts,
    input  logic [TS_W-1:0] in_end_ts,
    input  logic [TS_W-1:0] in_ts,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [7:0]      m_data,
    output logic            m_last
);
    localparam int RB = rec_bytes(TS_W);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = FLUSH_TIMEOUT > 1 ? $clog2(FLUSH_TIMEOUT) : 1;
    localparam int IW = $clog2(RB);
    localparam logic [CW-1:0] RPP   = CW'(RECS_PER_PKT);
    localparam logic [TW-1:0] TMAX  = TW'(FLUSH_TIMEOUT - 1);
    localparam logic [IW-1:0] HLAST = IW'(HDR_BYTES - 1);
    localparam logic [IW-1:0] RLAST = IW'(RB - 1);
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [TS_W-1:0] start_ts;
        logic [TS_W-1:0] end_ts;
        logic [TS_W-1:0] ts;
    } rec_t;
    rec_t            in_rec, head;
    logic [CW-1:0]   count;
    logic            full, empty, push, pop, hs, launch, rec_done, pkt_done;
    state_t          state_q, state_d;
    logic [7:0]      seq_q, n_q, rec_q;
    logic [IW-1:0]   idx_q;
    logic [TW-1:0]   timer_q;
    logic [8*RB-1:0] rec_flat, rec_sh;
    assign in_rec   = '{id: in_id, start_ts: in_start_ts, end_ts: in_end_ts, ts: in_ts};
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign hs       = m_valid && m_ready;
    assign launch   = state_q == IDLE && (count >= RPP || (!empty && timer_q == TMAX));
    assign rec_done = state_q == REC && idx_q == RLAST;
    assign pkt_done = rec_done && rec_q == n_q - 8'd1;
    assign pop      = hs && rec_done;
    assign rec_flat = {8'(head.id), head.start_ts, head.end_ts, head.ts};
    assign rec_sh   = rec_flat << (8 * idx_q);
    ts_record_fifo #(
        .W    ($bits(rec_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .din_i  (in_rec),
        .pop_i  (pop),
        .dout_o (head),
        .count_o(count),
        .full_o (full),
        .empty_o(empty)
    );
    // FSM state register
    always_ff @(posedge clk)
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    // FSM next state: launch from IDLE, header then records, back to IDLE after the last record
    always_comb begin
        state_d = launch ? HDR :
                  hs && state_q == HDR && idx_q == HLAST ? REC :
                  hs && pkt_done ? IDLE : state_q;
    end
    // FSM outputs: byte mux driven purely from registered state so it holds during stalls
    always_comb begin
        m_valid = state_q != IDLE;
        m_last  = pkt_done;
        m_data  = state_q == HDR ? (idx_q == '0 ? MAGIC : idx_q == IW'(1) ? seq_q : n_q) :
                  state_q == REC ? rec_sh[8*RB-1 -: 8] : 8'h00;
    end
    // packet bookkeeping and oldest-record age timer
    always_ff @(posedge clk)
        if (rst) begin
            seq_q   <= '0;
            n_q     <= '0;
            rec_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
        end else begin
            if (launch) begin
                n_q   <= count >= RPP ? 8'(RPP) : 8'(count);
                idx_q <= '0;
                rec_q <= '0;
            end else if (hs) begin
                idx_q <= (state_q == HDR && idx_q == HLAST) || rec_done ? '0 : idx_q + 1'b1;
                if (rec_done) rec_q <= rec_q + 8'd1;
                if (pkt_done) seq_q <= seq_q + 8'd1;
            end
            timer_q <= empty || launch ? '0 :
                       state_q == IDLE && count < RPP && timer_q != TMAX ? timer_q + 1'b1 : timer_q;
        end
endmodule

// File: tb/tb_ts_record_packetizer.sv
// tb_ts_record_packetizer: directed scenarios checked against a packet-level byte model
module tb_ts_record_packetizer;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] s;
        logic [63:0] e;
        logic [63:0] t;
    } trec_t;
    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic        clk = 0, rst = 1, in_valid = 0, m_ready = 1;
    logic [3:0]  in_id = 0;
    logic [63:0] in_start_ts = 0, in_end_ts = 0, in_ts = 0;
    logic        in_ready, m_valid, m_last;
    logic [7:0]  m_data;

    always #5 clk = ~clk;

    ts_record_packetizer #(
        .ID_W(4), .TS_W(64), .RECS_PER_PKT(2), .FIFO_DEPTH(4), .FLUSH_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .in_start_ts(in_start_ts), .in_end_ts(in_end_ts), .in_ts(in_ts),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    int         nchk = 0, nerr = 0, cyc = 0;
    exp_t       exp_q[$];
    trec_t      mrec[$];
    logic [7:0] mseq = 0;
    logic [7:0] seqs[$];
    logic [7:0] cur[64], last_pkt[64];
    int         pos = 0, last_len = 0, mark_cyc = -1, rise_cyc = -1;
    logic       prev_v = 0, prev_r = 0, prev_l = 0;
    logic [7:0] prev_d = 0;
    bit         rand_rdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        nchk++;
        if (got !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, expv);
        end
    endtask

    function automatic trec_t mk(input logic [3:0] i, input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        mk = '{id: i, s: a, e: b, t: c};
    endfunction

    function automatic trec_t gen(input int i);
        gen = mk(4'(i), 64'(i) * 64'h101, 64'(i) * 64'h101 + 64'(i + 7), 64'(i + 7));
    endfunction

    function automatic void put(input logic [7:0] d, input logic l);
        exp_q.push_back('{d: d, l: l});
    endfunction

    // one packet of n records taken from the model's record queue
    task automatic emit(input int n);
        trec_t r;
        logic [191:0] f;
        put(8'hA5, 0);
        put(mseq, 0);
        put(8'(n), 0);
        for (int k = 0; k < n; k++) begin
            r = mrec.pop_front();
            put({4'h0, r.id}, 0);
            f = {r.s, r.e, r.t};
            for (int b = 0; b < 24; b++) put(f[191-8*b -: 8], k == n - 1 && b == 23);
        end
        mseq++;
    endtask

    always @(posedge clk)
        if (rand_rdy) begin
            #1;
            m_ready = 1'($urandom_range(0, 1));
        end

    // compare process: stall stability, no mid-packet gaps, every accepted byte against the model
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pos = 0;
            prev_v = 0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, prev_d);
                chk("hold_last", m_last, prev_l);
            end
            if (pos > 0 && !m_valid) chk("valid_drop", m_valid, 1);
            if (m_valid && !prev_v) rise_cyc = cyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL extra_byte: got %0h with no byte expected", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", m_data, e.d);
                    chk("last", m_last, e.l);
                end
                if (pos < 64) cur[pos] = m_data;
                pos++;
                if (pos == 28) mark_cyc = cyc;
                if (m_last) begin
                    last_len = pos;
                    last_pkt = cur;
                    seqs.push_back(cur[1]);
                    pos = 0;
                end
            end
            prev_v = m_valid;
            prev_r = m_ready;
            prev_d = m_data;
            prev_l = m_last;
        end
    end

    task automatic push(input trec_t r, output int acc);
        bit ok = 0;
        in_valid = 1;
        in_id = r.id;
        in_start_ts = r.s;
        in_end_ts = r.e;
        in_ts = r.t;
        acc = -1;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                acc = cyc;
            end
        end
        if (!ok) begin
            nchk++;
            nerr++;
            $display("FAIL push_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic drain;
        bit ok = 0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(posedge clk);
            #1;
            ok = exp_q.size() == 0 && !m_valid;
        end
        chk("drain_left", 64'(exp_q.size()), 0);
        chk("drain_idle", m_valid, 0);
    endtask

    task automatic do_reset;
        rand_rdy = 0;
        rst = 1;
        in_valid = 0;
        m_ready = 1;
        repeat (2) @(posedge clk);
        exp_q.delete();
        mrec.delete();
        seqs.delete();
        mseq = 0;
        mark_cyc = -1;
        #1;
        rst = 0;
        m_ready = 1;
        @(negedge clk);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_data", m_data, 0);
        chk("rst_ready", in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        trec_t r1, r2, r, q4[5];
        int a, t, a5;
        r1 = mk(4'd3, 64'h10, 64'h25, 64'h15);
        r2 = mk(4'd5, 64'h30, 64'h40, 64'h10);

        do_reset();
        mrec.push_back(r1);
        mrec.push_back(r2);
        emit(2);
        push(r1, a);
        push(r2, a);
        drain();
        chk("s1_len", 64'(last_len), 53);
        chk("s1_magic", last_pkt[0], 8'hA5);
        chk("s1_seq", last_pkt[1], 8'h00);
        chk("s1_n", last_pkt[2], 8'h02);
        chk("s1_id0", last_pkt[3], 8'h03);
        chk("s1_start0", last_pkt[11], 8'h10);
        chk("s1_end0", last_pkt[19], 8'h25);
        chk("s1_ts0", last_pkt[27], 8'h15);
        chk("s1_id1", last_pkt[28], 8'h05);
        chk("s1_ts1", last_pkt[52], 8'h10);

        do_reset();
        r = mk(4'd9, 64'h1000, 64'h1234, 64'h234);
        mrec.push_back(r);
        emit(1);
        push(r, t);
        drain();
        chk("s2_rise", 64'(rise_cyc - t), 17);
        chk("s2_len", 64'(last_len), 28);
        chk("s2_n", last_pkt[2], 8'h01);
        chk("s2_ts", last_pkt[27], 8'h34);

        do_reset();
        rand_rdy = 1;
        mrec.push_back(r1);
        mrec.push_back(r2);
        emit(2);
        push(r1, a);
        push(r2, a);
        drain();
        rand_rdy = 0;
        chk("s3_len", 64'(last_len), 53);
        chk("s3_id1", last_pkt[28], 8'h05);

        do_reset();
        m_ready = 0;
        for (int i = 0; i < 5; i++) begin
            q4[i] = mk(4'(i + 1), 64'(i) * 64'h100 + 64'h1, 64'(i) * 64'h100 + 64'h80, 64'h7F);
            mrec.push_back(q4[i]);
        end
        emit(2);
        emit(2);
        emit(1);
        for (int i = 0; i < 4; i++) push(q4[i], a);
        @(negedge clk);
        chk("s4_full", in_ready, 0);
        @(posedge clk);
        #1;
        m_ready = 1;
        push(q4[4], a5);
        chk("s4_accept5", 64'(a5), 64'(mark_cyc + 1));
        drain();
        chk("s4_npkt", 64'(seqs.size()), 3);
        chk("s4_seq2", seqs[2], 8'h02);
        chk("s4_n", last_pkt[2], 8'h01);
        chk("s4_id", last_pkt[3], 8'h05);

        do_reset();
        for (int i = 0; i < 514; i++) mrec.push_back(gen(i));
        for (int p = 0; p < 257; p++) emit(2);
        for (int i = 0; i < 514; i++) push(gen(i), a);
        drain();
        chk("s5_npkt", 64'(seqs.size()), 257);
        chk("s5_seq1", seqs[1], 8'h01);
        chk("s5_seq255", seqs[255], 8'hFF);
        chk("s5_seq256", seqs[256], 8'h00);

        do_reset();
        mrec.push_back(r1);
        mrec.push_back(r2);
        emit(2);
        push(r1, a);
        push(r2, a);
        for (int k = 0; k < 200 && pos != 10; k++) begin
            @(posedge clk);
            #1;
        end
        chk("s6_pos", 64'(pos), 10);
        rst = 1;
        exp_q.delete();
        mrec.delete();
        mseq = 0;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("s6_valid", m_valid, 0);
        chk("s6_ready", in_ready, 1);
        chk("s6_last", m_last, 0);
        @(posedge clk);
        #1;
        r = mk(4'd7, 64'h500, 64'h5A0, 64'hA0);
        mrec.push_back(r);
        mrec.push_back(r2);
        emit(2);
        push(r, a);
        push(r2, a);
        drain();
        chk("s6_seq", last_pkt[1], 8'h00);
        chk("s6_id", last_pkt[3], 8'h07);
        chk("s6_len", 64'(last_len), 53);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/ts_record_packetizer.md
Name: ts_record_packetizer

Overview:
Downstream stage of the event timestamper. It accepts completed timestamp records (id, start_ts, end_ts, ts) over a valid/ready handshake and buffers them in a record FIFO. It then serializes them into a byte stream of framed packets, each forming one UDP payload, for the UDP TX path. A packet is launched when RECS_PER_PKT records are buffered, or when the oldest buffered record has waited FLUSH_TIMEOUT cycles.

Parameters:
ID_W, 4, event ID width; must be ≤ 8.
TS_W, 64, timestamp width; must be a multiple of 8.
RECS_PER_PKT, 4, maximum records per packet; range 1..255.
FIFO_DEPTH, 8, record FIFO depth; must be ≥ RECS_PER_PKT and a power of 2.
FLUSH_TIMEOUT, 1024, cycles before a partial packet is flushed; must be ≥ 1.

Ports:
clk  in  1  clock; single clock domain
rst  in  1  synchronous, active-high reset
in_valid  in  1  record valid
in_ready  out  1  record accepted when in_valid && in_ready
in_id  in  ID_W  event ID
in_start_ts  in  TS_W  start timestamp
in_end_ts  in  TS_W  end timestamp
in_ts  in  TS_W  end - start delta; forwarded as-is, not recomputed
m_valid  out  1  output byte valid
m_ready  in  1  downstream accepts the byte when m_valid && m_ready
m_data  out  8  output byte
m_last  out  1  high on the final byte of a packet

Behaviour:
- Reset values: m_valid=0, m_last=0, m_data=0, in_ready=1 (the cycle after reset). FIFO is emptied, sequence number = 0, timer = 0, FSM in IDLE.
- in_ready = (fifo_count < FIFO_DEPTH), using the registered count. There is no push-through when the FIFO is full, even if a pop happens in the same cycle.
- Packet format, bytes sent in order:
  - Header (HDR_BYTES=3): 0xA5, seq[7:0], n (record count).
  - n records, each REC_BYTES = 1 + 3*TS_W/8 bytes (25 at the defaults).
  - Record layout: id zero-extended to 8 bits, then start_ts, end_ts, ts, each MSB first.
  - m_last is asserted on the last byte of the last record only.
- FSM states:
  - IDLE → HDR when fifo_count ≥ RECS_PER_PKT, or when fifo_count > 0 and timer == FLUSH_TIMEOUT-1. On this transition, n is latched as min(fifo_count, RECS_PER_PKT) and the byte index is cleared.
  - HDR: emits the 3 header bytes, then → REC.
  - REC: emits the record bytes for the FIFO head. The FIFO pops on acceptance of each record's last byte. After record n is popped → IDLE, and seq increments, wrapping 255→0.
- Latency:
  - m_valid rises the cycle after the IDLE→HDR decision.
  - A full packet takes a minimum of 3 + n*REC_BYTES cycles with m_ready held high.
  - There is one idle cycle between back-to-back packets.
- Output stability: while m_valid && !m_ready, m_data and m_last are held. m_valid never drops mid-packet. The byte index advances only on a handshake.
- Timer:
  - Counts only in IDLE while 0 < fifo_count < RECS_PER_PKT.
  - Cleared when the FIFO is empty or when a packet launches.
  - Not cleared by new pushes, so it measures the age of the oldest buffered record.
  - Saturates at FLUSH_TIMEOUT-1.
- Simultaneous events:
  - A push during a pop updates the count by +1-1 = 0.
  - A push landing on the launch cycle is not counted in n; it stays for the next packet.
- Packet size is capped at RECS_PER_PKT even if more records are buffered; the remainder triggers the next launch immediately from IDLE.
- Reset mid-packet: the partial packet is abandoned with no m_last. Next cycle m_valid=0, all buffered records are discarded, and seq restarts at 0.

Decomposition:
- Package ts_pkt_pkg holds:
  - MAGIC = 8'hA5 and HDR_BYTES = 3.
  - Parameterized record struct typedef (id, start_ts, end_ts, ts).
  - FSM state enum {IDLE, HDR, REC}.
  - REC_BYTES function of TS_W.
- Sub-module ts_record_fifo: synchronous FIFO of records with push/pop, count, full and empty. The head is available combinationally while not empty.
- The packetizer FSM, byte mux and timer live in the top.

Test Plan:
Bench params: ID_W=4, TS_W=64, RECS_PER_PKT=2, FIFO_DEPTH=4, FLUSH_TIMEOUT=16.
1. Push id=3/start=0x10/end=0x25/ts=0x15, then id=5/start=0x30/end=0x40/ts=0x10, with m_ready=1 → 53 bytes: A5 00 02, 03, 00..00 10, 00..00 25, 00..00 15, then the second record. m_last is high on byte 53 only.
2. Push a single record at cycle t, no more pushes → header A5 00 01 appears with m_valid rising at t+17. Packet is 28 bytes, with m_last on byte 28.
3. Repeat scenario 1 with m_ready randomly toggled at 50% → byte sequence identical. m_data/m_last are stable whenever m_valid && !m_ready.
4. Hold m_ready=0 and push 5 records → in_ready falls after the 4th is accepted. Release m_ready: the 5th is accepted the cycle after the first record's last byte. Output is three packets with counts 2, 2, 1 and seq 00, 01, 02.
5. Send 257 two-record packets → seq bytes 00..FF, then 00.
6. Assert rst for 1 cycle after 10 bytes of a packet → next cycle m_valid=0 and in_ready=1. The old records are never sent. The next packet carries seq 00.
